// File: rtl/rvfi_commit_queue_if.sv
// Bundles the allocation, completion and RVFI retire signals of the commit queue.
// Ports: flush and alloc request in, alloc grant/tag out; completion payload in;
// RVFI packet, sticky halt and sticky protocol error out.
interface rvfi_commit_queue_if #(
  parameter int DEPTH = 16,
  parameter int TAG_W = $clog2(DEPTH)
);
  logic             flush;
  logic             alloc_valid;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;
  logic             cmp_valid;
  logic [TAG_W-1:0] cmp_tag;
  logic [31:0]      cmp_inst;
  logic [63:0]      cmp_pc;
  logic [110:0]     cmp_regs;
  logic [103:0]     cmp_mem;
  logic             rvfi_valid;
  logic [63:0]      rvfi_order;
  logic [31:0]      rvfi_inst;
  logic [63:0]      rvfi_pc;
  logic [110:0]     rvfi_regs;
  logic [103:0]     rvfi_mem;
  logic             rvfi_halt;
  logic             err;

  // master: decode/writeback side that drives requests and watches the monitor outputs
  modport master (
    output flush, alloc_valid, cmp_valid, cmp_tag, cmp_inst, cmp_pc, cmp_regs, cmp_mem,
    input  alloc_ready, alloc_tag, rvfi_valid, rvfi_order, rvfi_inst, rvfi_pc,
           rvfi_regs, rvfi_mem, rvfi_halt, err
  );

  // slave: the commit queue itself
  modport slave (
    input  flush, alloc_valid, cmp_valid, cmp_tag, cmp_inst, cmp_pc, cmp_regs, cmp_mem,
    output alloc_ready, alloc_tag, rvfi_valid, rvfi_order, rvfi_inst, rvfi_pc,
           rvfi_regs, rvfi_mem, rvfi_halt, err
  );
endinterface

// File: rtl/rvfi_commit_queue.sv
// In-order commit tracker: slots allocated in program order, completed out of order
// by tag, retired one packet per cycle in allocation order onto the RVFI monitor port.
// Ports: clk, rst (sync, active-high), bus (slave modport of rvfi_commit_queue_if).
module rvfi_commit_queue #(
  parameter int DEPTH = 16,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input logic                clk,
  input logic                rst,
  rvfi_commit_queue_if.slave bus
);
  localparam int CNT_W = TAG_W + 1;

  logic [TAG_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic [DEPTH-1:0] busy, done;
  logic [63:0]      order_cnt;

  logic [31:0]  inst_q [DEPTH];
  logic [63:0]  pc_q   [DEPTH];
  logic [110:0] regs_q [DEPTH];
  logic [103:0] mem_q  [DEPTH];

  logic         valid_r, halt_r, err_r;
  logic [63:0]  order_r;
  logic [31:0]  inst_r;
  logic [63:0]  pc_r;
  logic [110:0] regs_r;
  logic [103:0] mem_r;

  logic         alloc_fire, cmp_fire, cmp_bad, retire, halt_hit;
  logic [110:0] regs_s;
  logic [103:0] mem_s;

  // No bypass: a full queue stays blocked even in a cycle that retires.
  assign bus.alloc_ready = (count != CNT_W'(DEPTH));
  assign bus.alloc_tag   = tail;

  // Flush wins over everything else happening in the same cycle.
  assign alloc_fire = bus.alloc_valid & bus.alloc_ready & ~bus.flush;
  assign cmp_fire   = bus.cmp_valid & ~bus.flush;
  // busy/done are the registered values, so a same-cycle alloc of cmp_tag reads as not busy.
  assign cmp_bad    = cmp_fire & (~busy[bus.cmp_tag] | done[bus.cmp_tag]);
  assign retire     = busy[head] & done[head] & ~bus.flush;

  // Zero the don't-care fields of the head packet before it is registered out.
  always_comb begin
    regs_s = regs_q[head];
    mem_s  = mem_q[head];
    if (regs_s[110:106] == 5'd0) regs_s[95:64] = 32'd0;
    if (regs_s[105:101] == 5'd0) regs_s[63:32] = 32'd0;
    if (regs_s[100:96]  == 5'd0) regs_s[31:0]  = 32'd0;
    mem_s[73:72] = 2'b00;
    for (int i = 0; i < 4; i++) begin
      if (!mem_s[68+i]) mem_s[32 + 8*i +: 8] = 8'd0;
      if (!mem_s[64+i]) mem_s[8*i +: 8]      = 8'd0;
    end
    halt_hit = (pc_q[head][63:32] == pc_q[head][31:0]) ||
               (inst_q[head] == 32'h0000_0063) ||
               (inst_q[head] == 32'h0000_006F) ||
               (inst_q[head] == 32'hF000_2013);
  end

  // Payload storage carries no reset; a slot is only read once its done bit is set.
  always_ff @(posedge clk) begin
    if (cmp_fire) begin
      inst_q[bus.cmp_tag] <= bus.cmp_inst;
      pc_q[bus.cmp_tag]   <= bus.cmp_pc;
      regs_q[bus.cmp_tag] <= bus.cmp_regs;
      mem_q[bus.cmp_tag]  <= bus.cmp_mem;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      busy      <= '0;
      done      <= '0;
      order_cnt <= '0;
      valid_r   <= 1'b0;
      order_r   <= '0;
      inst_r    <= '0;
      pc_r      <= '0;
      regs_r    <= '0;
      mem_r     <= '0;
      halt_r    <= 1'b0;
      err_r     <= 1'b0;
    end else if (bus.flush) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      busy    <= '0;
      done    <= '0;
      valid_r <= 1'b0;
    end else begin
      if (cmp_bad) err_r <= 1'b1;
      // Later assignments win: retire clears the head, alloc then claims the tail.
      if (cmp_fire) done[bus.cmp_tag] <= 1'b1;
      if (retire) begin
        busy[head] <= 1'b0;
        done[head] <= 1'b0;
        head       <= head + 1'b1;
      end
      if (alloc_fire) begin
        busy[tail] <= 1'b1;
        done[tail] <= 1'b0;
        tail       <= tail + 1'b1;
      end
      if (alloc_fire && !retire)      count <= count + 1'b1;
      else if (!alloc_fire && retire) count <= count - 1'b1;

      valid_r <= retire;
      if (retire) begin
        order_r   <= order_cnt;
        order_cnt <= order_cnt + 64'd1;
        inst_r    <= inst_q[head];
        pc_r      <= pc_q[head];
        regs_r    <= regs_s;
        mem_r     <= mem_s;
        if (halt_hit) halt_r <= 1'b1;
      end
    end
  end

  assign bus.rvfi_valid = valid_r;
  assign bus.rvfi_order = order_r;
  assign bus.rvfi_inst  = inst_r;
  assign bus.rvfi_pc    = pc_r;
  assign bus.rvfi_regs  = regs_r;
  assign bus.rvfi_mem   = mem_r;
  assign bus.rvfi_halt  = halt_r;
  assign bus.err        = err_r;
endmodule
